// File: rtl/contador_programa_if.sv
// Bus between the program-counter stage and the rest of the core.
// Handshake: there is no valid/ready pair here; Habilita is a plain
// per-cycle advance strobe sampled on every rising edge, and the outputs
// describe the registered PC state seen during the current cycle.
interface contador_programa_if #(
  parameter int LARGURA      = 8,
  parameter int LARGURA_CONT = 16
);
  logic                    Habilita;
  logic                    Desvio;
  logic [LARGURA-1:0]      Deslocamento;
  logic                    Salto;
  logic [LARGURA-1:0]      EnderecoSalto;
  logic                    Parar;
  logic [LARGURA-1:0]      PC;
  logic [LARGURA-1:0]      PCMais1;
  logic                    InstrucaoValida;
  logic                    Parado;
  logic [LARGURA_CONT-1:0] Retiradas;
  logic [1:0]              estado;

  modport master (
    output Habilita, Desvio, Deslocamento, Salto, EnderecoSalto, Parar,
    input  PC, PCMais1, InstrucaoValida, Parado, Retiradas, estado
  );

  modport slave (
    input  Habilita, Desvio, Deslocamento, Salto, EnderecoSalto, Parar,
    output PC, PCMais1, InstrucaoValida, Parado, Retiradas, estado
  );
endinterface

// File: rtl/contador_programa.sv
// Program-counter stage: holds the fetch address, offers PC+1 to the
// PC-source mux, selects the next PC (sequential / branch / jump), handles
// stall and halt, and keeps a saturating retired-instruction counter.
// The FSM state is exported on bus.estado for observation.
module contador_programa #(
  parameter int               LARGURA      = 8,
  parameter logic [LARGURA-1:0] VETOR_RESET = '0,
  parameter int               LARGURA_CONT = 16
) (
  input logic                Clock,
  input logic                Reset,
  contador_programa_if.slave bus
);

  typedef enum logic [1:0] {
    INICIO  = 2'd0,
    EXECUTA = 2'd1,
    PARADO  = 2'd2
  } estado_t;

  estado_t                 estado;
  logic [LARGURA-1:0]      pc;
  logic [LARGURA-1:0]      pc_mais1;
  logic [LARGURA-1:0]      alvo_desvio;
  logic [LARGURA_CONT-1:0] retiradas;
  logic                    valida;
  logic                    parado;

  // PC+1 and the branch target both wrap naturally at LARGURA bits; adding
  // the offset at full width is the same as sign-extending it.
  assign pc_mais1    = pc + LARGURA'(1);
  assign alvo_desvio = pc_mais1 + bus.Deslocamento;

  // FSM, PC register and retired counter; status outputs are registered
  // alongside the state so they change on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado    <= INICIO;
      pc        <= VETOR_RESET;
      retiradas <= '0;
      valida    <= 1'b0;
      parado    <= 1'b0;
    end else begin
      case (estado)
        INICIO: begin
          estado <= EXECUTA;
          valida <= 1'b1;
        end
        EXECUTA: begin
          if (bus.Habilita) begin
            if (retiradas != {LARGURA_CONT{1'b1}}) begin
              retiradas <= retiradas + LARGURA_CONT'(1);
            end
            if (bus.Parar) begin
              estado <= PARADO;
              valida <= 1'b0;
              parado <= 1'b1;
            end else if (bus.Salto) begin
              pc <= bus.EnderecoSalto;
            end else if (bus.Desvio) begin
              pc <= alvo_desvio;
            end else begin
              pc <= pc_mais1;
            end
          end
        end
        PARADO: begin
          valida <= 1'b0;
          parado <= 1'b1;
        end
        default: begin
          estado <= INICIO;
          valida <= 1'b0;
          parado <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC              = pc;
  assign bus.PCMais1         = pc_mais1;
  assign bus.InstrucaoValida = valida;
  assign bus.Parado          = parado;
  assign bus.Retiradas       = retiradas;
  assign bus.estado          = estado;

endmodule

// File: tb/tb_contador_programa.sv
// Directed bench for contador_programa: a 16-bit-counter instance carries
// the functional sequence, a 2-bit-counter instance covers saturation.
module tb_contador_programa;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  contador_programa_if #(.LARGURA(8), .LARGURA_CONT(16)) bus_a ();
  contador_programa_if #(.LARGURA(8), .LARGURA_CONT(2))  bus_b ();

  contador_programa #(.LARGURA(8), .VETOR_RESET(8'h00), .LARGURA_CONT(16)) dut_a (
    .Clock (clk),
    .Reset (rst_a),
    .bus   (bus_a.slave)
  );

  contador_programa #(.LARGURA(8), .VETOR_RESET(8'h00), .LARGURA_CONT(2)) dut_b (
    .Clock (clk),
    .Reset (rst_b),
    .bus   (bus_b.slave)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  // reference model of dut_a
  int          m_state;   // 0 bubble, 1 running, 2 halted
  logic [7:0]  m_pc;
  logic [15:0] m_ret;
  logic        m_val;
  logic        m_par;
  logic [1:0]  b_ret;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // Push the model's view of dut_a, then pop and compare each output.
  task automatic check_a(input string tag);
    logic [7:0] m_pcm;
    m_pcm = m_pc + 8'd1;
    push_exp({24'd0, m_pc});
    push_exp({24'd0, m_pcm});
    push_exp({31'd0, m_val});
    push_exp({31'd0, m_par});
    push_exp({16'd0, m_ret});
    chk({tag, ".pc"},        {24'd0, bus_a.PC});
    chk({tag, ".pcmais1"},   {24'd0, bus_a.PCMais1});
    chk({tag, ".valida"},    {31'd0, bus_a.InstrucaoValida});
    chk({tag, ".parado"},    {31'd0, bus_a.Parado});
    chk({tag, ".retiradas"}, {16'd0, bus_a.Retiradas});
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 8'h00;
    m_ret   = 16'd0;
    m_val   = 1'b0;
    m_par   = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model, wait for the edge and
  // land 1 time unit after it.
  task automatic drive_a(input logic hab, input logic sal, input logic des,
                         input logic [7:0] dsl, input logic [7:0] alvo,
                         input logic par);
    logic [7:0] pcm;
    bus_a.Habilita      = hab;
    bus_a.Salto         = sal;
    bus_a.Desvio        = des;
    bus_a.Deslocamento  = dsl;
    bus_a.EnderecoSalto = alvo;
    bus_a.Parar         = par;
    pcm = m_pc + 8'd1;
    if (m_state == 0) begin
      m_state = 1;
      m_val   = 1'b1;
    end else if (m_state == 1 && hab) begin
      m_ret = m_ret + 16'd1;
      if (par) begin
        m_state = 2;
        m_val   = 1'b0;
        m_par   = 1'b1;
      end else if (sal) begin
        m_pc = alvo;
      end else if (des) begin
        m_pc = pcm + dsl;
      end else begin
        m_pc = pcm;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus_a.Habilita = 1'b0; bus_a.Salto = 1'b0; bus_a.Desvio = 1'b0;
    bus_a.Deslocamento = 8'h00; bus_a.EnderecoSalto = 8'h00; bus_a.Parar = 1'b0;
    bus_b.Habilita = 1'b0; bus_b.Salto = 1'b0; bus_b.Desvio = 1'b0;
    bus_b.Deslocamento = 8'h00; bus_b.EnderecoSalto = 8'h00; bus_b.Parar = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    model_reset();
    b_ret = 2'd0;

    #12;
    check_a("in_reset");
    rst_a = 1'b0;
    #1;
    check_a("inicio");

    // 1: bubble, then sequential 00..04
    drive_a(1, 0, 0, 8'h00, 8'h00, 0);
    check_a("seq_bubble");
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 0, 0, 8'h00, 8'h00, 0);
      check_a("seq");
    end

    // 2: branches with negative and positive offsets
    drive_a(1, 1, 0, 8'h00, 8'h10, 0);
    check_a("jump_10");
    drive_a(1, 0, 1, 8'hFC, 8'h00, 0);
    check_a("branch_m4");
    drive_a(1, 0, 1, 8'h05, 8'h00, 0);
    check_a("branch_p5");

    // 3: wrap-around and jump/branch priority
    drive_a(1, 1, 0, 8'h00, 8'hFF, 0);
    check_a("at_ff");
    drive_a(1, 0, 0, 8'h00, 8'h00, 0);
    check_a("wrap_seq");
    drive_a(1, 1, 0, 8'h00, 8'hFF, 0);
    check_a("at_ff_again");
    drive_a(1, 0, 1, 8'hFE, 8'h00, 0);
    check_a("wrap_branch");
    drive_a(1, 1, 1, 8'h07, 8'hA0, 0);
    check_a("salto_wins");

    // 4: stall ignores control inputs
    drive_a(1, 1, 0, 8'h00, 8'h22, 0);
    check_a("jump_22");
    drive_a(0, 1, 0, 8'h00, 8'h99, 0);
    check_a("stall1");
    drive_a(0, 0, 1, 8'h40, 8'h00, 1);
    check_a("stall2");
    drive_a(0, 1, 1, 8'h40, 8'h77, 1);
    check_a("stall3");
    drive_a(1, 0, 0, 8'h00, 8'h00, 0);
    check_a("resume");

    // 5: halt beats jump, then everything is frozen
    drive_a(1, 1, 0, 8'h00, 8'h30, 0);
    check_a("jump_30");
    drive_a(1, 1, 0, 8'h00, 8'h55, 1);
    check_a("halt");
    drive_a(1, 1, 1, 8'h05, 8'h66, 0);
    check_a("halted1");
    drive_a(1, 0, 0, 8'h00, 8'h00, 1);
    check_a("halted2");

    // 6: asynchronous reset mid-cycle
    #3;
    rst_a = 1'b1;
    model_reset();
    #1;
    check_a("async_reset");
    #2;
    rst_a = 1'b0;

    // 6: saturation of a 2-bit counter
    rst_b = 1'b0;
    bus_b.Habilita = 1'b1;
    @(posedge clk);
    #1;
    push_exp(32'd0);
    chk("sat_bubble", {30'd0, bus_b.Retiradas});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (b_ret != 2'b11) b_ret = b_ret + 2'd1;
      push_exp({30'd0, b_ret});
      chk("sat", {30'd0, bus_b.Retiradas});
    end
    push_exp(32'd3);
    chk("sat_final", {30'd0, bus_b.Retiradas});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
